// File: rtl/lifo_stack_if.sv
// lifo_stack_if: push/pop request and status bundle for lifo_stack
interface lifo_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);
  logic             we;
  logic             re;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  modport master (
    output we, re, data_in,
    input  data_out, full, empty, almost_full, count, overflow, underflow
  );
  modport slave (
    input  we, re, data_in,
    output data_out, full, empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised synchronous LIFO with occupancy, almost-full, error pulses and replace-top
module lifo_stack #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input logic         clk,
  input logic         rst,
  lifo_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dout;
  logic             ovf;
  logic             udf;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             both;
  always_comb begin
    full    = cnt == CW'(DEPTH);
    empty   = cnt == '0;
    push    = bus.we && !bus.re;
    pop     = bus.re && !bus.we;
    both    = bus.we && bus.re;
    wr_idx  = AW'(cnt);
    top_idx = AW'(cnt - 1'b1);
  end
  // wr_idx is out of range only when full, and pushes are blocked then
  always_ff @(posedge clk) begin
    if (!rst && push && !full) mem[wr_idx] <= bus.data_in;
    if (!rst && both && !empty) mem[top_idx] <= bus.data_in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      dout <= '0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else begin
      ovf <= push && full;
      udf <= pop && empty;
      if (push && !full) cnt <= cnt + 1'b1;
      if (pop && !empty) begin
        dout <= mem[top_idx];
        cnt  <= cnt - 1'b1;
      end
      if (both) dout <= empty ? bus.data_in : mem[top_idx];
    end
  end
  assign bus.data_out    = dout;
  assign bus.count       = cnt;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = cnt >= CW'(AF_LEVEL);
  assign bus.overflow    = ovf;
  assign bus.underflow   = udf;
endmodule
